control_unit_gen2: RTL and testbench

CONTROL_UNIT_GEN2 -- requirements
Module: control_unit_gen2

---
 rtl/control_unit_gen2.sv | 222 ++++++++++++++++++++++
 tb/tb_control_unit_gen2.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_gen2.sv
// Sequencer for the stabilizer-simulation datapath: per-gate alpha/P/multQ/amplitude handshakes,
// final stabilizer readout beats, and a per-wait-state watchdog.
//  state    | meaning
//  IDLE     | waiting for start
//  LOAD     | latch next gate
//  A_INIT   | kick alpha computation
//  A_WAIT   | wait done_alpha
//  P_WAIT   | wait valid_P or readout request
//  M_INIT   | kick multQ
//  M_WAIT   | wait done_multQ
//  AMP_WAIT | wait done_amplitude
//  READOUT  | stream num_qubit beats
//  ERROR    | watchdog expired, hold until abort
module control_unit_gen2 #(
    parameter int num_qubit  = 4,
    parameter int TIMEOUT    = 1024,
    parameter int GATE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  done_alpha,
    input  logic                  valid_P,
    input  logic                  done_multQ,
    input  logic                  done_amplitude,
    input  logic                  literal_phase_readout,
    input  logic                  flag_anticommute,
    input  logic [1:0]            reg_gate_type,
    input  logic                  ready_out,
    output logic [3:0]            state_CU,
    output logic                  ld_gate_info,
    output logic                  determine_alpha,
    output logic                  ld_basis_index,
    output logic                  ld_global_phase,
    output logic                  alpha_beta,
    output logic                  determine_multQ,
    output logic                  ld_matchQ_index,
    output logic                  determine_amplitude,
    output logic                  ld_measure_update,
    output logic                  ld_reg_readout,
    output logic                  valid_out,
    output logic                  done_readout,
    output logic                  timeout_err,
    output logic [GATE_CNT_W-1:0] gate_count,
    output logic                  busy
);
    localparam int BEAT_W = (num_qubit > 1) ? $clog2(num_qubit) : 1;
    localparam int WD_W   = $clog2(TIMEOUT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(num_qubit - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_A_INIT   = 4'd2,
        S_A_WAIT   = 4'd3,
        S_P_WAIT   = 4'd4,
        S_M_INIT   = 4'd5,
        S_M_WAIT   = 4'd6,
        S_AMP_WAIT = 4'd7,
        S_READOUT  = 4'd8,
        S_ERROR    = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [GATE_CNT_W-1:0]   gate_q, gate_d;
    logic                    terr_q, terr_d;
    logic                    done_q, done_d;
    logic                    timeout_hit;
    logic                    in_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wd_q    <= '0;
            gate_q  <= '0;
            terr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wd_q    <= wd_d;
            gate_q  <= gate_d;
            terr_q  <= terr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wd_d        = wd_q;
        gate_d      = gate_q;
        terr_d      = terr_q;
        done_d      = 1'b0;
        timeout_hit = (wd_q == WD_LIMIT);
        in_wait     = (state_q == S_A_WAIT) || (state_q == S_M_WAIT) || (state_q == S_AMP_WAIT);

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            beat_d  = '0;
            terr_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        gate_d  = '0;
                    end
                end
                S_LOAD:   state_d = S_A_INIT;
                S_A_INIT: state_d = S_A_WAIT;
                S_A_WAIT: begin
                    if (done_alpha) begin
                        state_d = S_P_WAIT;
                    end else if (timeout_hit) begin
                        state_d = S_ERROR;
                        terr_d  = 1'b1;
                    end
                end
                S_P_WAIT: begin
                    if (valid_P) begin
                        state_d = S_M_INIT;
                    end else if (literal_phase_readout) begin
                        state_d = S_READOUT;
                        beat_d  = BEAT_LAST;
                    end
                end
                S_M_INIT: state_d = S_M_WAIT;
                S_M_WAIT: begin
                    if (done_multQ) begin
                        state_d = S_AMP_WAIT;
                    end else if (timeout_hit) begin
                        state_d = S_ERROR;
                        terr_d  = 1'b1;
                    end
                end
                S_AMP_WAIT: begin
                    if (done_amplitude) begin
                        state_d = S_LOAD;
                        if (gate_q != '1) gate_d = gate_q + GATE_CNT_W'(1);
                    end else if (timeout_hit) begin
                        state_d = S_ERROR;
                        terr_d  = 1'b1;
                    end
                end
                S_READOUT: begin
                    if (ready_out) begin
                        if (beat_q == '0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            beat_d = beat_q - BEAT_W'(1);
                        end
                    end
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end

        // Watchdog restarts on every state change, so it counts dwell time in the current wait state.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (in_wait) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_comb begin
        ld_gate_info        = 1'b0;
        determine_alpha     = 1'b0;
        ld_basis_index      = 1'b0;
        ld_global_phase     = 1'b0;
        alpha_beta          = 1'b0;
        determine_multQ     = 1'b0;
        ld_matchQ_index     = 1'b0;
        determine_amplitude = 1'b0;
        ld_measure_update   = 1'b0;
        valid_out           = 1'b0;
        case (state_q)
            S_LOAD:   ld_gate_info    = 1'b1;
            S_A_INIT: determine_alpha = 1'b1;
            S_M_INIT: determine_multQ = 1'b1;
            S_A_WAIT: ld_basis_index  = done_alpha;
            S_P_WAIT: begin
                if (valid_P) begin
                    if (reg_gate_type == 2'd3) ld_basis_index  = 1'b1;
                    else                       ld_global_phase = 1'b1;
                end
            end
            S_M_WAIT: begin
                ld_matchQ_index     = done_multQ;
                determine_amplitude = done_multQ;
            end
            S_AMP_WAIT: begin
                if (done_amplitude) begin
                    if (reg_gate_type == 2'd3) begin
                        ld_measure_update = flag_anticommute;
                    end else begin
                        ld_global_phase = 1'b1;
                        alpha_beta      = 1'b1;
                    end
                end
            end
            S_READOUT: valid_out = 1'b1;
            default: ;
        endcase
    end

    assign ld_reg_readout = valid_out & ready_out;
    assign state_CU       = state_q;
    assign done_readout   = done_q;
    assign timeout_err    = terr_q;
    assign gate_count     = gate_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_control_unit_gen2.sv
// Directed bench for control_unit_gen2: a cycle model of the sequencing rules checked every cycle,
// plus literal expectations on pulse counts and states for each scenario.
module tb_control_unit_gen2;
    localparam int NQ = 4;
    localparam int TO = 8;
    localparam int GW = 2;

    localparam int M_IDLE = 0, M_LOAD = 1, M_A_INIT = 2, M_A_WAIT = 3, M_P_WAIT = 4;
    localparam int M_M_INIT = 5, M_M_WAIT = 6, M_AMP_WAIT = 7, M_READOUT = 8, M_ERROR = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic done_alpha = 1'b0, valid_P = 1'b0, done_multQ = 1'b0, done_amplitude = 1'b0;
    logic literal_phase_readout = 1'b0, flag_anticommute = 1'b0, ready_out = 1'b0;
    logic [1:0] reg_gate_type = 2'd0;

    logic [3:0]    state_CU;
    logic          ld_gate_info, determine_alpha, ld_basis_index, ld_global_phase, alpha_beta;
    logic          determine_multQ, ld_matchQ_index, determine_amplitude, ld_measure_update;
    logic          ld_reg_readout, valid_out, done_readout, timeout_err, busy;
    logic [GW-1:0] gate_count;

    control_unit_gen2 #(.num_qubit(NQ), .TIMEOUT(TO), .GATE_CNT_W(GW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .done_alpha(done_alpha), .valid_P(valid_P), .done_multQ(done_multQ),
        .done_amplitude(done_amplitude), .literal_phase_readout(literal_phase_readout),
        .flag_anticommute(flag_anticommute), .reg_gate_type(reg_gate_type), .ready_out(ready_out),
        .state_CU(state_CU), .ld_gate_info(ld_gate_info), .determine_alpha(determine_alpha),
        .ld_basis_index(ld_basis_index), .ld_global_phase(ld_global_phase), .alpha_beta(alpha_beta),
        .determine_multQ(determine_multQ), .ld_matchQ_index(ld_matchQ_index),
        .determine_amplitude(determine_amplitude), .ld_measure_update(ld_measure_update),
        .ld_reg_readout(ld_reg_readout), .valid_out(valid_out), .done_readout(done_readout),
        .timeout_err(timeout_err), .gate_count(gate_count), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: state number, dwell time in the current state, beats left, gates done.
    int m_st = 0, m_dwell = 0, m_beats = 0, m_gc = 0;
    bit m_terr = 1'b0, m_done = 1'b0, m_live = 1'b0;

    always @(posedge clk) begin : model
        int nxt;
        if (rst) begin
            m_st = M_IDLE; m_dwell = 0; m_beats = 0; m_gc = 0;
            m_terr = 1'b0; m_done = 1'b0; m_live = 1'b1;
        end else begin
            nxt = m_st;
            m_done = 1'b0;
            if (abort && m_st != M_IDLE) begin
                nxt = M_IDLE; m_beats = 0; m_terr = 1'b0;
            end else if (m_st == M_IDLE) begin
                if (start) begin nxt = M_LOAD; m_gc = 0; end
            end else if (m_st == M_LOAD || m_st == M_A_INIT || m_st == M_M_INIT) begin
                nxt = m_st + 1;
            end else if (m_st == M_A_WAIT || m_st == M_M_WAIT || m_st == M_AMP_WAIT) begin
                if ((m_st == M_A_WAIT && done_alpha) || (m_st == M_M_WAIT && done_multQ)) begin
                    nxt = m_st + 1;
                end else if (m_st == M_AMP_WAIT && done_amplitude) begin
                    nxt = M_LOAD;
                    m_gc = (m_gc < (1 << GW) - 1) ? m_gc + 1 : m_gc;
                end else if (m_dwell == TO - 1) begin
                    nxt = M_ERROR; m_terr = 1'b1;
                end
            end else if (m_st == M_P_WAIT) begin
                if (valid_P) nxt = M_M_INIT;
                else if (literal_phase_readout) begin nxt = M_READOUT; m_beats = NQ - 1; end
            end else if (m_st == M_READOUT) begin
                if (ready_out) begin
                    if (m_beats == 0) begin nxt = M_IDLE; m_done = 1'b1; end
                    else m_beats = m_beats - 1;
                end
            end else if (m_st != M_ERROR) begin
                nxt = M_IDLE;
            end
            m_dwell = (nxt == m_st) ? m_dwell + 1 : 0;
            m_st = nxt;
        end
    end

    // Order: gate_info, alpha, basis, gphase, ab, multQ, matchQ, amp, meas_upd, reg_readout, valid, done, terr, busy
    function automatic logic [13:0] exp_ctl();
        logic [13:0] e;
        logic meas;
        e = '0;
        meas = (reg_gate_type == 2'd3);
        if (m_st == M_LOAD)   e[13] = 1'b1;
        if (m_st == M_A_INIT) e[12] = 1'b1;
        if (m_st == M_M_INIT) e[8]  = 1'b1;
        if (m_st == M_A_WAIT && done_alpha) e[11] = 1'b1;
        if (m_st == M_P_WAIT && valid_P) begin
            if (meas) e[11] = 1'b1; else e[10] = 1'b1;
        end
        if (m_st == M_M_WAIT && done_multQ) begin e[7] = 1'b1; e[6] = 1'b1; end
        if (m_st == M_AMP_WAIT && done_amplitude) begin
            if (meas) e[5] = flag_anticommute; else begin e[10] = 1'b1; e[9] = 1'b1; end
        end
        if (m_st == M_READOUT) begin e[3] = 1'b1; e[4] = ready_out; end
        e[2] = m_done;
        e[1] = m_terr;
        e[0] = (m_st != M_IDLE);
        return e;
    endfunction

    int n_gp = 0, n_bi = 0, n_mu = 0, n_rd = 0, n_done = 0;
    logic [7:0] gp_ab = '0;

    always @(negedge clk) begin : compare
        logic [13:0] act, exp_v;
        if (m_live) begin
            exp_v = exp_ctl();
            act = {ld_gate_info, determine_alpha, ld_basis_index, ld_global_phase, alpha_beta,
                   determine_multQ, ld_matchQ_index, determine_amplitude, ld_measure_update,
                   ld_reg_readout, valid_out, done_readout, timeout_err, busy};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL ctl t=%0t state=%0d actual=%b required=%b", $time, m_st, act, exp_v);
            end
            checks++;
            if (state_CU !== 4'(m_st)) begin
                errors++;
                $display("FAIL state_CU t=%0t actual=%0d required=%0d", $time, state_CU, m_st);
            end
            checks++;
            if (gate_count !== GW'(m_gc)) begin
                errors++;
                $display("FAIL gate_count t=%0t actual=%0d required=%0d", $time, gate_count, m_gc);
            end
            if (ld_global_phase === 1'b1) begin n_gp++; gp_ab = {gp_ab[6:0], alpha_beta}; end
            if (ld_basis_index === 1'b1) n_bi++;
            if (ld_measure_update === 1'b1) n_mu++;
            if (ld_reg_readout === 1'b1) n_rd++;
            if (done_readout === 1'b1) n_done++;
        end
    end

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_gp = 0; n_bi = 0; n_mu = 0; n_rd = 0; n_done = 0; gp_ab = '0;
    endtask

    // Runs one full gate starting from LOAD and ends back in LOAD.
    task automatic run_gate(input logic [1:0] typ, input logic flag);
        reg_gate_type = typ; flag_anticommute = flag;
        tick();
        tick();
        done_alpha = 1'b1; tick(); done_alpha = 1'b0;
        valid_P = 1'b1; tick(); valid_P = 1'b0;
        tick();
        done_multQ = 1'b1; tick(); done_multQ = 1'b0;
        done_amplitude = 1'b1; tick(); done_amplitude = 1'b0;
    endtask

    // IDLE -> READOUT through one alpha/P round with a readout request.
    task automatic go_readout();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        done_alpha = 1'b1; tick(); done_alpha = 1'b0;
        literal_phase_readout = 1'b1; tick(); literal_phase_readout = 1'b0;
    endtask

    initial begin : stim
        logic [5:0] pat;
        pat = 6'b110101;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        lit("reset_state", int'(state_CU), 0);
        lit("reset_gate_count", int'(gate_count), 0);
        lit("reset_terr", int'(timeout_err), 0);

        // Stabilizer gate with done_alpha one cycle into A_WAIT.
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        done_alpha = 1'b1; tick(); done_alpha = 1'b0;
        valid_P = 1'b1; tick(); valid_P = 1'b0;
        tick();
        done_multQ = 1'b1; tick(); done_multQ = 1'b0;
        done_amplitude = 1'b1; tick(); done_amplitude = 1'b0;
        lit("stab_state_load", int'(state_CU), 1);
        lit("stab_gate_count", int'(gate_count), 1);
        lit("stab_gphase_pulses", n_gp, 2);
        lit("stab_alpha_beta_order", int'(gp_ab[1:0]), 1);

        // Measurement gate, anticommuting.
        clear_counts();
        run_gate(2'd3, 1'b1);
        lit("meas_basis_pulses", n_bi, 2);
        lit("meas_update_pulses", n_mu, 1);
        lit("meas_gphase_pulses", n_gp, 0);
        lit("meas_gate_count", int'(gate_count), 2);

        // valid_P beats literal_phase_readout; then M_WAIT watchdog expiry.
        reg_gate_type = 2'd0; flag_anticommute = 1'b0;
        tick(); tick();
        done_alpha = 1'b1; tick(); done_alpha = 1'b0;
        valid_P = 1'b1; literal_phase_readout = 1'b1; tick();
        valid_P = 1'b0; literal_phase_readout = 1'b0;
        lit("both_to_m_init", int'(state_CU), 5);
        tick();
        repeat (TO - 1) tick();
        lit("m_wait_before_limit", int'(state_CU), 6);
        tick();
        lit("m_wait_timeout_state", int'(state_CU), 9);
        lit("m_wait_timeout_err", int'(timeout_err), 1);
        start = 1'b1; repeat (3) tick(); start = 1'b0;
        lit("error_holds", int'(state_CU), 9);
        abort = 1'b1; tick(); abort = 1'b0;
        lit("abort_error_state", int'(state_CU), 0);
        lit("abort_clears_terr", int'(timeout_err), 0);
        lit("gate_count_holds_abort", int'(gate_count), 2);

        // Readout with ready_out low before beats 2 and 3.
        clear_counts();
        go_readout();
        lit("readout_state", int'(state_CU), 8);
        for (int i = 0; i < 6; i++) begin
            ready_out = pat[i];
            tick();
        end
        ready_out = 1'b0;
        lit("readout_end_state", int'(state_CU), 0);
        lit("readout_done_pulse", int'(done_readout), 1);
        lit("readout_beats", n_rd, 4);
        tick();
        lit("readout_done_clears", int'(done_readout), 0);
        lit("readout_done_count", n_done, 1);

        // Abort mid-readout.
        clear_counts();
        go_readout();
        ready_out = 1'b1; tick(); ready_out = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        lit("abort_readout_state", int'(state_CU), 0);
        tick(); tick();
        lit("abort_readout_no_done", n_done, 0);
        lit("abort_readout_beats", n_rd, 1);

        // done_alpha on the last watchdog cycle wins; AMP_WAIT expiry; rst in ERROR.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        repeat (TO - 1) tick();
        lit("a_wait_at_limit", int'(state_CU), 3);
        done_alpha = 1'b1; tick(); done_alpha = 1'b0;
        lit("done_beats_timeout", int'(state_CU), 4);
        lit("done_beats_timeout_err", int'(timeout_err), 0);
        valid_P = 1'b1; tick(); valid_P = 1'b0;
        tick();
        done_multQ = 1'b1; tick(); done_multQ = 1'b0;
        repeat (TO) tick();
        lit("amp_timeout_state", int'(state_CU), 9);
        lit("amp_timeout_err", int'(timeout_err), 1);
        rst = 1'b1; abort = 1'b1; tick(); rst = 1'b0; abort = 1'b0;
        lit("rst_error_state", int'(state_CU), 0);
        lit("rst_error_terr", int'(timeout_err), 0);
        lit("rst_error_gate_count", int'(gate_count), 0);
        lit("rst_error_valid", int'(valid_out), 0);

        // gate_count saturation.
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) run_gate(2'd0, 1'b0);
        lit("gate_count_saturates", int'(gate_count), 3);
        abort = 1'b1; tick(); abort = 1'b0;
        lit("sat_abort_state", int'(state_CU), 0);
        lit("sat_abort_gate_count", int'(gate_count), 3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL time_limit reached actual=%0t required<200000", $time);
        $fatal(1, "time limit");
    end
endmodule
